// File: rtl/jk_moore_bank.sv
// Bank of independent two-state j/k Moore machines with dwell lockout,
// registered edge pulses and saturating per-channel transition counters.
module jk_moore_bank #(
  parameter int CHANNELS = 4,
  parameter int DWELL_W  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                mode,
  input  logic [DWELL_W-1:0]        min_dwell,
  input  logic [CHANNELS-1:0]       j,
  input  logic [CHANNELS-1:0]       k,
  input  logic                      cnt_clr,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       rise,
  output logic [CHANNELS-1:0]       fall,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*CNT_W-1:0] trans_cnt
);

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_e;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e             state_q, state_d;
    logic [DWELL_W-1:0] lock_q, lock_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rise_q, fall_q;
    logic               trans;

    always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      trans   = 1'b0;
      if (lock_q != '0) begin
        lock_d = lock_q - 1'b1;
      end else begin
        unique case (state_q)
          OFF: if (j[g] && !(k[g] && mode == 2'd2)) state_d = ON;
          ON:  if (k[g] && !(j[g] && mode == 2'd1)) state_d = OFF;
        endcase
        trans = (state_d != state_q);
        if (trans) lock_d = min_dwell;
      end
    end

    // A clear at the same edge as a transition drops that transition's count.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)
        cnt_d = '0;
      else if (trans && cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= OFF;
        lock_q  <= '0;
        cnt_q   <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        lock_q  <= lock_d;
        cnt_q   <= cnt_d;
        rise_q  <= trans && (state_d == ON);
        fall_q  <= trans && (state_d == OFF);
      end
    end

    assign out[g]                   = (state_q == ON);
    assign rise[g]                  = rise_q;
    assign fall[g]                  = fall_q;
    assign busy[g]                  = (lock_q != '0);
    assign trans_cnt[g*CNT_W +: CNT_W] = cnt_q;
  end

endmodule
